// File: rtl/text_writer.sv
// Terminal-style byte writer for the 80x25 text display.
// Writes chars/attrs, tracks a cursor, clears and scrolls the screen RAM.
module text_writer #(
   parameter int         COLS         = 80,
   parameter int         ROWS         = 25,
   parameter logic [7:0] DEFAULT_ATTR = 8'h70
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  in_data,
   input  logic [7:0]  in_attr,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [11:0] mem_addr,
   output logic [7:0]  mem_char_o,
   output logic [7:0]  mem_colr_o,
   output logic        mem_we,
   input  logic [7:0]  mem_char_i,
   input  logic [7:0]  mem_colr_i,
   output logic [6:0]  cursor_col,
   output logic [4:0]  cursor_row,
   output logic        busy
);

   typedef enum logic [2:0] {
      IDLE, CLR, SCR_RD, SCR_WAIT, SCR_WR, SCR_FILL
   } state_t;

   localparam logic [6:0] COL_MAX = 7'(COLS - 1);
   localparam logic [4:0] ROW_MAX = 5'(ROWS - 1);
   localparam logic [4:0] SRC_MAX = 5'(ROWS - 2);

   state_t     state;
   logic [4:0] op_row;
   logic [6:0] op_col;
   logic       hs;
   logic       printable;

   assign hs        = in_valid & in_ready;
   assign printable = (in_data >= 8'h20) && (in_data <= 8'h7E);

   // Byte interpreter plus the clear / scroll sequencer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= CLR;
         op_row     <= '0;
         op_col     <= '0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_char_o <= '0;
         mem_colr_o <= '0;
         cursor_col <= '0;
         cursor_row <= '0;
         in_ready   <= 1'b0;
         busy       <= 1'b1;
      end else begin
         mem_we <= 1'b0;
         unique case (state)
            IDLE: begin
               in_ready <= 1'b1;
               busy     <= 1'b0;
               if (hs) begin
                  unique case (1'b1)
                     printable: begin
                        mem_we     <= 1'b1;
                        mem_addr   <= {cursor_row, cursor_col};
                        mem_char_o <= in_data;
                        mem_colr_o <= in_attr;
                        if (cursor_col == COL_MAX) begin
                           cursor_col <= '0;
                           if (cursor_row == ROW_MAX) begin
                              state    <= SCR_RD;
                              op_row   <= '0;
                              op_col   <= '0;
                              in_ready <= 1'b0;
                              busy     <= 1'b1;
                           end else begin
                              cursor_row <= cursor_row + 5'd1;
                           end
                        end else begin
                           cursor_col <= cursor_col + 7'd1;
                        end
                     end
                     (in_data == 8'h0D): begin
                        cursor_col <= '0;
                     end
                     (in_data == 8'h0A): begin
                        if (cursor_row == ROW_MAX) begin
                           state    <= SCR_RD;
                           op_row   <= '0;
                           op_col   <= '0;
                           in_ready <= 1'b0;
                           busy     <= 1'b1;
                        end else begin
                           cursor_row <= cursor_row + 5'd1;
                        end
                     end
                     (in_data == 8'h08): begin
                        if (cursor_col != 7'd0)
                           cursor_col <= cursor_col - 7'd1;
                     end
                     (in_data == 8'h0C): begin
                        cursor_col <= '0;
                        cursor_row <= '0;
                        state      <= CLR;
                        op_row     <= '0;
                        op_col     <= '0;
                        in_ready   <= 1'b0;
                        busy       <= 1'b1;
                     end
                     default: ;
                  endcase
               end
            end
            CLR: begin
               mem_we     <= 1'b1;
               mem_addr   <= {op_row, op_col};
               mem_char_o <= 8'h20;
               mem_colr_o <= DEFAULT_ATTR;
               if (op_col == COL_MAX) begin
                  op_col <= '0;
                  if (op_row == ROW_MAX) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     op_row <= op_row + 5'd1;
                  end
               end else begin
                  op_col <= op_col + 7'd1;
               end
            end
            SCR_RD: begin
               mem_addr <= {op_row + 5'd1, op_col};
               state    <= SCR_WAIT;
            end
            SCR_WAIT: begin
               state <= SCR_WR;
            end
            SCR_WR: begin
               mem_we     <= 1'b1;
               mem_addr   <= {op_row, op_col};
               mem_char_o <= mem_char_i;
               mem_colr_o <= mem_colr_i;
               if (op_col == COL_MAX) begin
                  op_col <= '0;
                  if (op_row == SRC_MAX) begin
                     state <= SCR_FILL;
                  end else begin
                     op_row <= op_row + 5'd1;
                     state  <= SCR_RD;
                  end
               end else begin
                  op_col <= op_col + 7'd1;
                  state  <= SCR_RD;
               end
            end
            SCR_FILL: begin
               mem_we     <= 1'b1;
               mem_addr   <= {ROW_MAX, op_col};
               mem_char_o <= 8'h20;
               mem_colr_o <= DEFAULT_ATTR;
               if (op_col == COL_MAX) begin
                  op_col <= '0;
                  state  <= IDLE;
                  busy   <= 1'b0;
               end else begin
                  op_col <= op_col + 7'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_text_writer.sv
// Bench for text_writer: RAM model, write log and a screen-level
// reference model fed by the same byte stream.
module tb_text_writer;

   localparam int LIMIT = 12000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  in_data = '0;
   logic [7:0]  in_attr = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [11:0] mem_addr;
   logic [7:0]  mem_char_o;
   logic [7:0]  mem_colr_o;
   logic        mem_we;
   logic [7:0]  mem_char_i = '0;
   logic [7:0]  mem_colr_i = '0;
   logic [6:0]  cursor_col;
   logic [4:0]  cursor_row;
   logic        busy;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int bad_cnt = 0;

   typedef struct {
      int         cyc;
      logic [11:0] addr;
      logic [7:0]  ch;
      logic [7:0]  co;
   } wr_t;
   wr_t log_q[$];

   logic [7:0] ram_ch [4096];
   logic [7:0] ram_co [4096];

   logic [7:0] m_ch [25][80];
   logic [7:0] m_co [25][80];
   int m_row = 0;
   int m_col = 0;

   text_writer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_data    (in_data),
      .in_attr    (in_attr),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .mem_addr   (mem_addr),
      .mem_char_o (mem_char_o),
      .mem_colr_o (mem_colr_o),
      .mem_we     (mem_we),
      .mem_char_i (mem_char_i),
      .mem_colr_i (mem_colr_i),
      .cursor_col (cursor_col),
      .cursor_row (cursor_row),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Synchronous RAM pair with one cycle of read latency.
   always @(posedge clk) begin
      if (mem_we === 1'b1) begin
         ram_ch[mem_addr] <= mem_char_o;
         ram_co[mem_addr] <= mem_colr_o;
      end
      mem_char_i <= ram_ch[mem_addr];
      mem_colr_i <= ram_co[mem_addr];
   end

   always @(posedge clk) cyc++;

   // Write log, sampled mid-cycle.
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         log_q.push_back('{cyc, mem_addr, mem_char_o, mem_colr_o});
         if (mem_addr[6:0] >= 7'd80 || mem_addr[11:7] >= 5'd25)
            bad_cnt++;
      end
   end

   function automatic void m_clear();
      for (int r = 0; r < 25; r++)
         for (int c = 0; c < 80; c++) begin
            m_ch[r][c] = 8'h20;
            m_co[r][c] = 8'h70;
         end
   endfunction

   function automatic void m_scroll();
      for (int r = 0; r < 24; r++)
         for (int c = 0; c < 80; c++) begin
            m_ch[r][c] = m_ch[r+1][c];
            m_co[r][c] = m_co[r+1][c];
         end
      for (int c = 0; c < 80; c++) begin
         m_ch[24][c] = 8'h20;
         m_co[24][c] = 8'h70;
      end
   endfunction

   function automatic void m_byte(input logic [7:0] d, input logic [7:0] a);
      if (d >= 8'h20 && d <= 8'h7E) begin
         m_ch[m_row][m_col] = d;
         m_co[m_row][m_col] = a;
         m_col++;
         if (m_col == 80) begin
            m_col = 0;
            if (m_row == 24) m_scroll();
            else m_row++;
         end
      end else if (d == 8'h0D) begin
         m_col = 0;
      end else if (d == 8'h0A) begin
         if (m_row == 24) m_scroll();
         else m_row++;
      end else if (d == 8'h08) begin
         if (m_col > 0) m_col--;
      end else if (d == 8'h0C) begin
         m_clear();
         m_row = 0;
         m_col = 0;
      end
   endfunction

   function automatic int screen_diffs();
      int n;
      logic [11:0] a;
      n = 0;
      for (int r = 0; r < 25; r++)
         for (int c = 0; c < 80; c++) begin
            a = {5'(r), 7'(c)};
            if (ram_ch[a] !== m_ch[r][c] || ram_co[a] !== m_co[r][c])
               n++;
         end
      return n;
   endfunction

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d, input logic [7:0] a);
      int n;
      n = 0;
      in_data  = d;
      in_attr  = a;
      in_valid = 1'b1;
      while (in_ready !== 1'b1 && n < LIMIT) begin
         step();
         n++;
      end
      checks++;
      if (n >= LIMIT) begin
         errors++;
         $display("FAIL send_timeout: in_ready=%b want 1", in_ready);
      end else begin
         m_byte(d, a);
         step();
      end
   endtask

   task automatic wait_ready(input string tag);
      int n;
      n = 0;
      in_valid = 1'b0;
      while (in_ready !== 1'b1 && n < LIMIT) begin
         step();
         n++;
      end
      checks++;
      if (n >= LIMIT) begin
         errors++;
         $display("FAIL %s_timeout: in_ready=%b want 1", tag, in_ready);
      end
   endtask

   task automatic goto(input int row, input int col);
      send(8'h0C, 8'h00);
      for (int i = 0; i < row; i++) send(8'h0A, 8'h00);
      for (int i = 0; i < col; i++) send(8'h2E, 8'h07);
      in_valid = 1'b0;
      step();
   endtask

   task automatic test_reset();
      int c0, ok;
      bit seen [4096];
      rst_n = 1'b0;
      in_valid = 1'b0;
      repeat (3) step();
      checks++;
      if (mem_we !== 1'b0 || mem_addr !== 12'h000) begin
         errors++;
         $display("FAIL reset_mem: we=%b addr=%h want 0/000", mem_we, mem_addr);
      end
      checks++;
      if (mem_char_o !== 8'h00 || mem_colr_o !== 8'h00) begin
         errors++;
         $display("FAIL reset_data: %h/%h want 00/00", mem_char_o, mem_colr_o);
      end
      checks++;
      if (cursor_row !== 5'd0 || cursor_col !== 7'd0 ||
          in_ready !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL reset_ctl: cur=(%0d,%0d) rdy=%b busy=%b want (0,0) 0 1",
                  cursor_row, cursor_col, in_ready, busy);
      end
      rst_n = 1'b1;
      c0 = cyc;
      log_q.delete();
      m_clear();
      m_row = 0;
      m_col = 0;
      wait_ready("reset_clear");
      checks++;
      if (log_q.size() !== 2000) begin
         errors++;
         $display("FAIL clear_count: got %0d want 2000", log_q.size());
      end
      ok = 0;
      foreach (log_q[i]) begin
         if (log_q[i].addr[11:7] < 5'd25 && log_q[i].addr[6:0] < 7'd80 &&
             log_q[i].ch == 8'h20 && log_q[i].co == 8'h70 &&
             !seen[log_q[i].addr]) begin
            seen[log_q[i].addr] = 1'b1;
            ok++;
         end
      end
      checks++;
      if (ok !== 2000) begin
         errors++;
         $display("FAIL clear_cover: got %0d cells want 2000", ok);
      end
      if (log_q.size() > 0) begin
         checks++;
         if (log_q[0].cyc !== c0 + 1) begin
            errors++;
            $display("FAIL clear_start: cyc %0d want %0d", log_q[0].cyc, c0 + 1);
         end
         checks++;
         if (cyc !== log_q[log_q.size()-1].cyc + 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_end: ready cyc %0d busy=%b want %0d 0",
                     cyc, busy, log_q[log_q.size()-1].cyc + 1);
         end
      end
      step();
      checks++;
      if (screen_diffs() !== 0) begin
         errors++;
         $display("FAIL clear_screen: %0d diffs want 0", screen_diffs());
      end
   endtask

   task automatic test_print();
      log_q.delete();
      send(8'h48, 8'h1C);
      send(8'h69, 8'h1C);
      in_valid = 1'b0;
      step();
      checks++;
      if (log_q.size() !== 2) begin
         errors++;
         $display("FAIL print_count: got %0d want 2", log_q.size());
      end else begin
         checks++;
         if (log_q[0].addr !== 12'h000 || log_q[0].ch !== 8'h48 ||
             log_q[0].co !== 8'h1C) begin
            errors++;
            $display("FAIL print_h: %h %h/%h want 000 48/1c",
                     log_q[0].addr, log_q[0].ch, log_q[0].co);
         end
         checks++;
         if (log_q[1].addr !== 12'h001 || log_q[1].ch !== 8'h69 ||
             log_q[1].co !== 8'h1C || log_q[1].cyc !== log_q[0].cyc + 1) begin
            errors++;
            $display("FAIL print_i: %h %h/%h cyc+%0d want 001 69/1c +1",
                     log_q[1].addr, log_q[1].ch, log_q[1].co,
                     log_q[1].cyc - log_q[0].cyc);
         end
      end
      checks++;
      if (cursor_row !== 5'd0 || cursor_col !== 7'd2) begin
         errors++;
         $display("FAIL print_cursor: (%0d,%0d) want (0,2)", cursor_row, cursor_col);
      end
   endtask

   task automatic test_control();
      goto(3, 10);
      log_q.delete();
      send(8'h08, 8'h00);
      checks++;
      if (cursor_row !== 5'd3 || cursor_col !== 7'd9) begin
         errors++;
         $display("FAIL ctl_bs: (%0d,%0d) want (3,9)", cursor_row, cursor_col);
      end
      send(8'h0D, 8'h00);
      checks++;
      if (cursor_row !== 5'd3 || cursor_col !== 7'd0) begin
         errors++;
         $display("FAIL ctl_cr: (%0d,%0d) want (3,0)", cursor_row, cursor_col);
      end
      send(8'h0A, 8'h00);
      checks++;
      if (cursor_row !== 5'd4 || cursor_col !== 7'd0) begin
         errors++;
         $display("FAIL ctl_lf: (%0d,%0d) want (4,0)", cursor_row, cursor_col);
      end
      send(8'h08, 8'h00);
      send(8'h07, 8'h55);
      send(8'h80, 8'h55);
      in_valid = 1'b0;
      step();
      step();
      checks++;
      if (cursor_row !== 5'd4 || cursor_col !== 7'd0) begin
         errors++;
         $display("FAIL ctl_junk: (%0d,%0d) want (4,0)", cursor_row, cursor_col);
      end
      checks++;
      if (log_q.size() !== 0) begin
         errors++;
         $display("FAIL ctl_nowrite: %0d writes want 0", log_q.size());
      end
   endtask

   task automatic test_wrap();
      goto(5, 79);
      log_q.delete();
      send(8'h41, 8'h2E);
      in_valid = 1'b0;
      step();
      step();
      checks++;
      if (log_q.size() !== 1 || log_q[0].addr !== {5'd5, 7'd79} ||
          log_q[0].ch !== 8'h41) begin
         errors++;
         $display("FAIL wrap_write: n=%0d addr=%h want 1 %h",
                  log_q.size(), log_q.size() ? log_q[0].addr : 12'hfff,
                  {5'd5, 7'd79});
      end
      checks++;
      if (cursor_row !== 5'd6 || cursor_col !== 7'd0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL wrap_cursor: (%0d,%0d) busy=%b want (6,0) 0",
                  cursor_row, cursor_col, busy);
      end
   endtask

   task automatic test_scroll();
      int n, fill;
      bit got_x, got_z;
      bit seen [80];
      send(8'h0C, 8'h00);
      send(8'h0A, 8'h00);
      send(8'h58, 8'h40);
      for (int i = 0; i < 23; i++) send(8'h0A, 8'h00);
      send(8'h08, 8'h00);
      for (int i = 0; i < 5; i++) send(8'h2E, 8'h07);
      send(8'h5A, 8'h15);
      for (int i = 0; i < 3; i++) send(8'h08, 8'h00);
      in_valid = 1'b0;
      step();
      step();
      log_q.delete();
      send(8'h0A, 8'h00);
      in_valid = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < LIMIT) begin
         step();
         n++;
      end
      checks++;
      if (n !== 5840) begin
         errors++;
         $display("FAIL scroll_busy: %0d cycles want 5840", n);
      end
      wait_ready("scroll");
      step();
      got_x = 0;
      got_z = 0;
      fill = 0;
      foreach (log_q[i]) begin
         if (log_q[i].addr == 12'h000 && log_q[i].ch == 8'h58 &&
             log_q[i].co == 8'h40) got_x = 1;
         if (log_q[i].addr == {5'd23, 7'd5} && log_q[i].ch == 8'h5A)
            got_z = 1;
         if (log_q[i].addr[11:7] == 5'd24 && log_q[i].addr[6:0] < 7'd80 &&
             log_q[i].ch == 8'h20 && log_q[i].co == 8'h70 &&
             !seen[log_q[i].addr[6:0]]) begin
            seen[log_q[i].addr[6:0]] = 1'b1;
            fill++;
         end
      end
      checks++;
      if (!got_x || !got_z) begin
         errors++;
         $display("FAIL scroll_move: x=%0d z=%0d want 1 1", got_x, got_z);
      end
      checks++;
      if (fill !== 80) begin
         errors++;
         $display("FAIL scroll_fill: %0d cells want 80", fill);
      end
      checks++;
      if (cursor_row !== 5'd24 || cursor_col !== 7'd3) begin
         errors++;
         $display("FAIL scroll_cursor: (%0d,%0d) want (24,3)", cursor_row, cursor_col);
      end
      checks++;
      if (screen_diffs() !== 0) begin
         errors++;
         $display("FAIL scroll_screen: %0d diffs want 0", screen_diffs());
      end
   endtask

   task automatic test_reset_mid_scroll();
      int c0;
      send(8'h0A, 8'h00);
      in_valid = 1'b0;
      repeat (99) step();
      rst_n = 1'b0;
      step();
      checks++;
      if (mem_we !== 1'b0 || cursor_row !== 5'd0 || cursor_col !== 7'd0 ||
          busy !== 1'b1 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid: we=%b cur=(%0d,%0d) busy=%b rdy=%b want 0 (0,0) 1 0",
                  mem_we, cursor_row, cursor_col, busy, in_ready);
      end
      step();
      rst_n = 1'b1;
      c0 = cyc;
      log_q.delete();
      m_clear();
      m_row = 0;
      m_col = 0;
      wait_ready("rst_mid");
      step();
      checks++;
      if (log_q.size() !== 2000 || log_q[0].cyc !== c0 + 1 ||
          log_q[0].addr !== 12'h000) begin
         errors++;
         $display("FAIL rst_mid_clear: n=%0d want 2000 from cyc %0d", log_q.size(), c0 + 1);
      end
      checks++;
      if (screen_diffs() !== 0) begin
         errors++;
         $display("FAIL rst_mid_screen: %0d diffs want 0", screen_diffs());
      end
   endtask

   task automatic test_random();
      int k;
      logic [7:0] d;
      send(8'h0C, 8'h00);
      for (int i = 0; i < 10; i++) send(8'h0A, 8'h00);
      for (int i = 0; i < 260; i++) begin
         k = $urandom_range(0, 99);
         if (k < 78) d = 8'($urandom_range(32, 126));
         else if (k < 84) d = 8'h0D;
         else if (k < 90) d = 8'h0A;
         else if (k < 95) d = 8'h08;
         else if (k == 95) d = 8'h0C;
         else if (k < 99) d = 8'(8'h80 + $urandom_range(0, 127));
         else d = 8'h1B;
         send(d, 8'($urandom_range(0, 255)));
         if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) step();
         end
      end
      wait_ready("random");
      step();
      checks++;
      if (cursor_row !== 5'(m_row) || cursor_col !== 7'(m_col)) begin
         errors++;
         $display("FAIL rand_cursor: (%0d,%0d) want (%0d,%0d)",
                  cursor_row, cursor_col, m_row, m_col);
      end
      checks++;
      if (screen_diffs() !== 0) begin
         errors++;
         $display("FAIL rand_screen: %0d diffs want 0", screen_diffs());
      end
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) begin
         ram_ch[i] = 8'h00;
         ram_co[i] = 8'h00;
      end
      test_reset();
      test_print();
      test_control();
      test_wrap();
      test_scroll();
      test_reset_mid_scroll();
      test_random();
      checks++;
      if (bad_cnt !== 0) begin
         errors++;
         $display("FAIL bad_addr: %0d writes outside screen want 0", bad_cnt);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #950000;
      $display("FAIL watchdog: time limit reached");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog");
   end

endmodule
